// File: rtl/isa_pkg.sv
// Shared ISA definitions for the program-load path.
//   opcode_e : 4-bit opcode space
//   cw_t     : 11-bit decoded control word, same bit layout the control decoder emits
//   Cw*      : control word produced by each opcode (load/store cover both sizes)
//   instr_t  : 32-bit instruction word layout
package isa_pkg;

  localparam int unsigned CwW    = 11;
  localparam int unsigned InstrW = 32;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpB    = 4'h1,
    OpBeq  = 4'h2,
    OpBlt  = 4'h3,
    OpLw   = 4'h4,
    OpLb   = 4'h5,
    OpSw   = 4'h6,
    OpSb   = 4'h7,
    OpAdd  = 4'h8,
    OpAddi = 4'h9,
    OpSub  = 4'hA,
    OpDiv  = 4'hB,
    OpShl  = 4'hC
  } opcode_e;

  typedef struct packed {
    logic [1:0] branch_sel;
    logic       reg_we;
    logic [1:0] ext_sel;
    logic       alu_b_sel;
    logic [1:0] alu_ctrl;
    logic       set_flags;
    logic       mem_we;
    logic       wb_sel;
  } cw_t;

  localparam cw_t CwNop   = 11'h000;
  localparam cw_t CwB     = 11'h28C;
  localparam cw_t CwBeq   = 11'h48C;
  localparam cw_t CwBlt   = 11'h68C;
  localparam cw_t CwLoad  = 11'h101;
  localparam cw_t CwStore = 11'h002;
  localparam cw_t CwAdd   = 11'h100;
  localparam cw_t CwAddi  = 11'h160;
  localparam cw_t CwSub   = 11'h108;
  localparam cw_t CwDiv   = 11'h110;
  localparam cw_t CwShl   = 11'h118;

  typedef struct packed {
    opcode_e     opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
  } instr_t;

  function automatic instr_t pack_instr(input opcode_e     opcode,
                                        input logic [3:0]  rd,
                                        input logic [3:0]  rs1,
                                        input logic [3:0]  rs2,
                                        input logic [15:0] imm);
    instr_t w;
    w.opcode = opcode;
    w.rd     = rd;
    w.rs1    = rs1;
    w.rs2    = rs2;
    w.imm    = imm;
    return w;
  endfunction

endpackage

// File: rtl/cw_to_opcode.sv
// Combinational re-encoder: decoded control word back to its opcode.
//   cw_i        : 11-bit control word
//   size_byte_i : selects the byte variant for load/store, ignored otherwise
//   opcode_o    : matching opcode (OpNop when illegal)
//   legal_o     : 1 when cw_i matches exactly one opcode's control word
module cw_to_opcode
  import isa_pkg::*;
(
  input  cw_t     cw_i,
  input  logic    size_byte_i,
  output opcode_e opcode_o,
  output logic    legal_o
);

  always_comb begin
    opcode_o = OpNop;
    legal_o  = 1'b1;
    case (cw_i)
      CwNop:   opcode_o = OpNop;
      CwB:     opcode_o = OpB;
      CwBeq:   opcode_o = OpBeq;
      CwBlt:   opcode_o = OpBlt;
      // Word and byte variants share a control word; only the size bit tells them apart.
      CwLoad:  opcode_o = size_byte_i ? OpLb : OpLw;
      CwStore: opcode_o = size_byte_i ? OpSb : OpSw;
      CwAdd:   opcode_o = OpAdd;
      CwAddi:  opcode_o = OpAddi;
      CwSub:   opcode_o = OpSub;
      CwDiv:   opcode_o = OpDiv;
      CwShl:   opcode_o = OpShl;
      default: begin
        opcode_o = OpNop;
        legal_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts one decoded control bundle plus operands per handshake, re-encodes
// it into a 32-bit instruction and writes it to the next sequential IMEM address.
//   clk_i, rst_ni           : clock, async active-low reset
//   clear_i                 : rewind write pointer and zero counters on the next edge
//   in_valid_i / in_ready_o : bundle handshake (one bundle per two cycles at best)
//   branch_sel_i .. wb_sel_i: control word fields
//   size_byte_i             : byte variant select for load/store
//   rd_i, rs1_i, rs2_i, imm_i : operands
//   imem_we_o/addr_o/wdata_o: registered IMEM write port
//   instr_count_o, full_o   : words written since reset/clear, memory full flag
//   err_illegal_o, err_count_o : illegal bundle pulse and saturating count
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int unsigned IMEM_AW = 6,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [1:0]         branch_sel_i,
  input  logic               reg_we_i,
  input  logic [1:0]         ext_sel_i,
  input  logic               alu_b_sel_i,
  input  logic [1:0]         alu_ctrl_i,
  input  logic               set_flags_i,
  input  logic               mem_we_i,
  input  logic               wb_sel_i,
  input  logic               size_byte_i,
  input  logic [3:0]         rd_i,
  input  logic [3:0]         rs1_i,
  input  logic [3:0]         rs2_i,
  input  logic [15:0]        imm_i,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [INSTR_W-1:0] imem_wdata_o,
  output logic [IMEM_AW:0]   instr_count_o,
  output logic               full_o,
  output logic               err_illegal_o,
  output logic [7:0]         err_count_o
);

  localparam int unsigned     Depth    = 2 ** IMEM_AW;
  localparam logic [IMEM_AW:0] DepthCnt = (IMEM_AW + 1)'(Depth);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e               state_q;
  logic                 in_ready_q;
  logic                 imem_we_q;
  logic [IMEM_AW-1:0]   imem_addr_q;
  logic [INSTR_W-1:0]   imem_wdata_q;
  logic                 err_illegal_q;
  logic                 full_q;
  logic                 legal_q;
  logic [IMEM_AW-1:0]   wr_ptr_q;
  logic [IMEM_AW:0]     instr_count_q;
  logic [7:0]           err_count_q;

  cw_t                  cw;
  opcode_e              opcode;
  logic                 legal;
  instr_t               word;
  logic [IMEM_AW:0]     count_inc;
  logic                 accept;

  assign cw.branch_sel = branch_sel_i;
  assign cw.reg_we     = reg_we_i;
  assign cw.ext_sel    = ext_sel_i;
  assign cw.alu_b_sel  = alu_b_sel_i;
  assign cw.alu_ctrl   = alu_ctrl_i;
  assign cw.set_flags  = set_flags_i;
  assign cw.mem_we     = mem_we_i;
  assign cw.wb_sel     = wb_sel_i;

  cw_to_opcode u_cw_to_opcode (
    .cw_i        (cw),
    .size_byte_i (size_byte_i),
    .opcode_o    (opcode),
    .legal_o     (legal)
  );

  always_comb begin
    word      = pack_instr(opcode, rd_i, rs1_i, rs2_i, imm_i);
    count_inc = instr_count_q + 1'b1;
  end

  // Ready is registered except for the clear qualifier, so clear blocks an accept in the
  // very cycle it is raised.
  assign in_ready_o = in_ready_q & ~clear_i;
  assign accept     = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      in_ready_q    <= 1'b1;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      err_illegal_q <= 1'b0;
      full_q        <= 1'b0;
      legal_q       <= 1'b0;
      wr_ptr_q      <= '0;
      instr_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      // Strobes are single-cycle by construction.
      imem_we_q     <= 1'b0;
      err_illegal_q <= 1'b0;

      if (clear_i) begin
        // In WRITE the strobe is already on the port this cycle, so the write still lands.
        state_q       <= StIdle;
        in_ready_q    <= 1'b1;
        full_q        <= 1'b0;
        wr_ptr_q      <= '0;
        instr_count_q <= '0;
        err_count_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              state_q       <= StWrite;
              in_ready_q    <= 1'b0;
              legal_q       <= legal;
              imem_we_q     <= legal;
              err_illegal_q <= ~legal;
              imem_addr_q   <= wr_ptr_q;
              imem_wdata_q  <= INSTR_W'(word);
            end
          end

          StWrite: begin
            if (legal_q) begin
              wr_ptr_q      <= wr_ptr_q + 1'b1;
              instr_count_q <= count_inc;
              if (count_inc == DepthCnt) begin
                state_q    <= StFull;
                full_q     <= 1'b1;
                in_ready_q <= 1'b0;
              end else begin
                state_q    <= StIdle;
                in_ready_q <= 1'b1;
              end
            end else begin
              if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 1'b1;
              end
              state_q    <= StIdle;
              in_ready_q <= 1'b1;
            end
          end

          StFull: begin
            // Only clear or reset leave this state.
            in_ready_q <= 1'b0;
            full_q     <= 1'b1;
          end

          default: begin
            state_q    <= StIdle;
            in_ready_q <= 1'b1;
            full_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign imem_we_o     = imem_we_q;
  assign imem_addr_o   = imem_addr_q;
  assign imem_wdata_o  = imem_wdata_q;
  assign instr_count_o = instr_count_q;
  assign full_o        = full_q;
  assign err_illegal_o = err_illegal_q;
  assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  localparam int unsigned Aw = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] cw_in = '0;
  logic        size_byte = 1'b0;
  logic [3:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [15:0] imm = '0;
  logic        imem_we;
  logic [Aw-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [Aw:0] instr_count;
  logic        full;
  logic        err_illegal;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  instr_encoder_loader #(.IMEM_AW(Aw), .INSTR_W(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .branch_sel_i  (cw_in[10:9]),
    .reg_we_i      (cw_in[8]),
    .ext_sel_i     (cw_in[7:6]),
    .alu_b_sel_i   (cw_in[5]),
    .alu_ctrl_i    (cw_in[4:3]),
    .set_flags_i   (cw_in[2]),
    .mem_we_i      (cw_in[1]),
    .wb_sel_i      (cw_in[0]),
    .size_byte_i   (size_byte),
    .rd_i          (rd),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .imm_i         (imm),
    .imem_we_o     (imem_we),
    .imem_addr_o   (imem_addr),
    .imem_wdata_o  (imem_wdata),
    .instr_count_o (instr_count),
    .full_o        (full),
    .err_illegal_o (err_illegal),
    .err_count_o   (err_count)
  );

  typedef struct packed {
    logic [10:0] cw;
    logic        sb;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
    logic        legal;
    logic [3:0]  op;
  } vec_t;

  typedef struct packed {
    logic          is_err;
    logic [Aw-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_ptr    = 0;
  int   m_err    = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Scoreboard: every write or illegal pulse seen on the port must match the oldest
  // outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (imem_we || err_illegal)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", {30'd0, imem_we, err_illegal}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.is_err) begin
          chk("err_pulse", {30'd0, imem_we, err_illegal}, 32'd1);
        end else begin
          chk("write_strobe", {30'd0, imem_we, err_illegal}, 32'd2);
          chk("write_addr", 32'(imem_addr), 32'(e.addr));
          chk("write_data", imem_wdata, e.data);
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    cw_in = v.cw; size_byte = v.sb; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
  endtask

  // Wait for ready, hand over one bundle and return just after the WRITE cycle ends.
  task automatic send(input vec_t v, input bit clr_in_write);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("send_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    if (v.legal) begin
      sb_q.push_back('{is_err: 1'b0, addr: Aw'(m_ptr), data: {v.op, v.rd, v.rs1, v.rs2, v.imm}});
    end else begin
      sb_q.push_back('{is_err: 1'b1, addr: '0, data: '0});
    end
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (clr_in_write) clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    if (clr_in_write) begin
      m_ptr = 0;
      m_err = 0;
    end else if (v.legal) begin
      m_ptr++;
    end else if (m_err < 255) begin
      m_err++;
    end
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    chk({tag, "_count"}, 32'(instr_count), 32'(m_ptr));
    chk({tag, "_errcnt"}, 32'(err_count), 32'(m_err));
  endtask

  vec_t vecs[16];
  vec_t add_v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    //               cw       sb    rd     rs1    rs2    imm       legal op
    vecs[0]  = '{11'h160, 1'b0, 4'd1,  4'd2,  4'd0,  16'h0005, 1'b1, 4'h9};
    vecs[1]  = '{11'h101, 1'b1, 4'd3,  4'd4,  4'd0,  16'h0010, 1'b1, 4'h5};
    vecs[2]  = '{11'h101, 1'b0, 4'd3,  4'd4,  4'd0,  16'h0010, 1'b1, 4'h4};
    vecs[3]  = '{11'h7FF, 1'b0, 4'd7,  4'd7,  4'd7,  16'hFFFF, 1'b0, 4'h0};
    vecs[4]  = '{11'h000, 1'b0, 4'd0,  4'd0,  4'd0,  16'h0000, 1'b1, 4'h0};
    vecs[5]  = '{11'h28C, 1'b0, 4'd0,  4'd0,  4'd0,  16'hFFFC, 1'b1, 4'h1};
    vecs[6]  = '{11'h48C, 1'b1, 4'd0,  4'd5,  4'd6,  16'h0020, 1'b1, 4'h2};
    vecs[7]  = '{11'h68C, 1'b0, 4'd0,  4'd8,  4'd9,  16'h8000, 1'b1, 4'h3};
    vecs[8]  = '{11'h002, 1'b0, 4'd0,  4'd10, 4'd11, 16'h0004, 1'b1, 4'h6};
    vecs[9]  = '{11'h002, 1'b1, 4'd0,  4'd10, 4'd11, 16'h0005, 1'b1, 4'h7};
    vecs[10] = '{11'h100, 1'b1, 4'd12, 4'd13, 4'd14, 16'h0000, 1'b1, 4'h8};
    vecs[11] = '{11'h161, 1'b0, 4'd1,  4'd1,  4'd1,  16'h1234, 1'b0, 4'h0};
    vecs[12] = '{11'h108, 1'b0, 4'd15, 4'd1,  4'd2,  16'h0000, 1'b1, 4'hA};
    vecs[13] = '{11'h110, 1'b0, 4'd2,  4'd3,  4'd4,  16'h0000, 1'b1, 4'hB};
    vecs[14] = '{11'h001, 1'b1, 4'd2,  4'd3,  4'd4,  16'h0000, 1'b0, 4'h0};
    vecs[15] = '{11'h118, 1'b0, 4'd6,  4'd5,  4'd4,  16'h0003, 1'b1, 4'hC};
    add_v    = '{11'h100, 1'b0, 4'd1,  4'd2,  4'd3,  16'h0000, 1'b1, 4'h8};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err_illegal", 32'(err_illegal), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);

    // Encode table sweep
    for (int i = 0; i < 16; i++) begin
      send(vecs[i], 1'b0);
      check_counts($sformatf("vec%0d", i));
    end

    // clear and in_valid together: clear wins, nothing accepted
    @(negedge clk);
    drive(add_v);
    clear = 1'b1;
    in_valid = 1'b1;
    #1 chk("clr_valid_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 begin
      clear = 1'b0;
      in_valid = 1'b0;
    end
    m_ptr = 0;
    m_err = 0;
    check_counts("clr_valid");
    chk("clr_valid_ready_after", 32'(in_ready), 32'd1);

    // clear during WRITE: write lands at addr1, then everything rewinds
    send(add_v, 1'b0);
    add_v.imm = 16'hBEEF;
    send(add_v, 1'b1);
    check_counts("clr_write");
    chk("clr_write_ready", 32'(in_ready), 32'd1);
    add_v.imm = 16'h0042;
    send(add_v, 1'b0);
    check_counts("after_clr");

    // Fill the whole memory
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    m_ptr = 0;
    m_err = 0;
    for (int i = 0; i < 64; i++) begin
      add_v.rd  = 4'(i);
      add_v.imm = 16'(i * 3 + 1);
      send(add_v, 1'b0);
    end
    check_counts("fill");
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 in_valid = 1'b0;
    check_counts("full_hold");
    chk("full_hold_full", 32'(full), 32'd1);

    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    m_ptr = 0;
    check_counts("full_clr");
    chk("full_clr_full", 32'(full), 32'd0);
    chk("full_clr_ready", 32'(in_ready), 32'd1);

    // Reset asserted mid-WRITE
    @(negedge clk);
    sb_q.push_back('{is_err: 1'b0, addr: '0, data: '0});
    drive(add_v);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("rst_mid_we_before", 32'(imem_we), 32'd1);
    void'(sb_q.pop_back());
    rst_n = 1'b0;
    #1 chk("rst_mid_we_after", 32'(imem_we), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_err = 0;
    check_counts("rst_mid");
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_full", 32'(full), 32'd0);
    add_v.imm = 16'h0777;
    send(add_v, 1'b0);
    check_counts("rst_mid_next");

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
